pulpino_fpga_io_ctrl: RTL

Parametrised board-side I/O and boot controller for the PULPino FPGA wrapper, placed between the board pins and `pulpino_top`.
- Synchronises and optionally debounces a configurable-width GPIO input bus, and emits per-pin edge pulses.
- Sequences SoC reset release and fetch enable, so the core never starts fetching before reset has been held for a defined time and the external fetch request is stable.

---
 rtl/pulpino_fpga_pkg.sv | 31 +++
 rtl/pulpino_fpga_io_ctrl_gpio_debounce.sv | 106 ++++++++++
 rtl/pulpino_fpga_io_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pulpino_fpga_pkg.sv
// -----------------------------------------------------------------------------
// pulpino_fpga_pkg
// Shared types and constants for the PULPino FPGA board I/O controller.
//   - boot_state_e : boot sequencer state, 2-bit encoding shown on debug LEDs
//   - DEF_*        : default parameter values for pulpino_fpga_io_ctrl
//   - SYNC_STAGES  : depth of every clock-domain-crossing synchroniser
//   - cnt_width()  : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package pulpino_fpga_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    WAIT_FE = 2'd1,
    DELAY   = 2'd2,
    RUN     = 2'd3
  } boot_state_e;

  localparam int DEF_GPIO_W    = 32;
  localparam int DEF_DEB_CYC   = 1000;
  localparam int DEF_RST_HOLD  = 16;
  localparam int DEF_FETCH_DLY = 8;

  localparam int SYNC_STAGES   = 2;

  // Width of a counter that must hold values 0..n-1; a 1-bit counter is the
  // minimum so that n==1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulpino_fpga_io_ctrl_gpio_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce
// One GPIO input channel: 2-flop synchroniser, optional debounce counter,
// conditioned value register and registered edge pulses.
//
// Build option: PULPINO_FPGA_DEBOUNCE_EN
//   defined   - a change is accepted only after DEB_CYC consecutive synced
//               cycles differing from the current value.
//   undefined - the synced value is registered once (no counter); DEB_CYC
//               has no effect.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset
//   pad_i   in  raw pad input, asynchronous to clk
//   val_o   out conditioned value
//   rise_o  out one-cycle pulse, coincident with val_o going 0->1
//   fall_o  out one-cycle pulse, coincident with val_o going 1->0
// -----------------------------------------------------------------------------
module gpio_debounce
  import pulpino_fpga_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic val_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   val_q, val_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
  end

`ifdef PULPINO_FPGA_DEBOUNCE_EN
  localparam int               CNT_W   = cnt_width(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synced input has disagreed with the
  // accepted value; any agreement restarts the count, so glitches shorter
  // than DEB_CYC cycles never reach val_o.
  always_comb begin
    val_d  = val_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (synced == val_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      val_d  = synced;
      cnt_d  = '0;
      rise_d = synced;
      fall_d = ~synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Single register stage after the synchroniser; the pulses compare the
  // incoming synced bit against the value being replaced.
  always_comb begin
    val_d  = synced;
    rise_d = synced & ~val_q;
    fall_d = ~synced & val_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      val_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      val_q  <= val_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign val_o  = val_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/pulpino_fpga_io_ctrl.sv
// -----------------------------------------------------------------------------
// pulpino_fpga_io_ctrl
// Board-side I/O and boot controller sitting between the board pins and
// pulpino_top. Conditions the GPIO inputs (one gpio_debounce per bit) and
// sequences SoC reset release and fetch enable.
//
// Build option: PULPINO_FPGA_DEBOUNCE_EN (selects debounced GPIO inputs,
// see gpio_debounce); the boot sequencer is identical in both builds.
//
// Ports:
//   clk             in  system clock
//   rst_n           in  synchronous active-low reset
//   fetch_enable_i  in  board fetch-enable switch, asynchronous
//   gpio_pad_i      in  [GPIO_W] raw board GPIO inputs, asynchronous
//   gpio_in_o       out [GPIO_W] conditioned GPIO value
//   gpio_rise_o     out [GPIO_W] one-cycle pulse on accepted 0->1 change
//   gpio_fall_o     out [GPIO_W] one-cycle pulse on accepted 1->0 change
//   soc_rst_no      out SoC reset, active-low
//   fetch_enable_o  out sequenced fetch enable
//   boot_state_o    out [2] boot state (HOLD/WAIT_FE/DELAY/RUN)
// -----------------------------------------------------------------------------
module pulpino_fpga_io_ctrl
  import pulpino_fpga_pkg::*;
#(
  parameter int GPIO_W    = DEF_GPIO_W,
  parameter int DEB_CYC   = DEF_DEB_CYC,
  parameter int RST_HOLD  = DEF_RST_HOLD,
  parameter int FETCH_DLY = DEF_FETCH_DLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_enable_i,
  input  logic [GPIO_W-1:0] gpio_pad_i,
  output logic [GPIO_W-1:0] gpio_in_o,
  output logic [GPIO_W-1:0] gpio_rise_o,
  output logic [GPIO_W-1:0] gpio_fall_o,
  output logic              soc_rst_no,
  output logic              fetch_enable_o,
  output logic [1:0]        boot_state_o
);

  // ---------------------------------------------------------------------------
  // GPIO conditioning, one independent channel per bit
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < GPIO_W; gi++) begin : g_gpio
      gpio_debounce #(
        .DEB_CYC(DEB_CYC)
      ) u_gpio_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (gpio_pad_i[gi]),
        .val_o  (gpio_in_o[gi]),
        .rise_o (gpio_rise_o[gi]),
        .fall_o (gpio_fall_o[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fetch-enable synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] fe_sync_q, fe_sync_d;
  logic                   fe_synced;

  assign fe_synced = fe_sync_q[SYNC_STAGES-1];

  always_comb begin
    fe_sync_d = {fe_sync_q[SYNC_STAGES-2:0], fetch_enable_i};
  end

  // ---------------------------------------------------------------------------
  // Boot sequencer
  // One shared counter serves both HOLD and DELAY; it is sized for the longer
  // of the two and is cleared on every state change, so it only ever counts
  // up to the terminal value of the state it is in.
  // ---------------------------------------------------------------------------
  localparam int BOOT_MAX = (RST_HOLD > FETCH_DLY) ? RST_HOLD : FETCH_DLY;
  localparam int BCNT_W   = cnt_width(BOOT_MAX);

  localparam logic [BCNT_W-1:0] HOLD_LAST = BCNT_W'(RST_HOLD - 1);
  localparam logic [BCNT_W-1:0] DLY_LAST  = BCNT_W'(FETCH_DLY - 1);

  boot_state_e       state_q, state_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic              soc_rst_n_q, soc_rst_n_d;
  logic              fetch_en_q, fetch_en_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    soc_rst_n_d = soc_rst_n_q;
    fetch_en_d  = fetch_en_q;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d       = '0;
          soc_rst_n_d = 1'b1;
          // A switch already on at reset skips WAIT_FE entirely.
          state_d     = fe_synced ? DELAY : WAIT_FE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_FE: begin
        cnt_d      = '0;
        fetch_en_d = 1'b0;
        if (fe_synced) begin
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (!fe_synced) begin
          state_d = WAIT_FE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d    = RUN;
          cnt_d      = '0;
          fetch_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!fe_synced) begin
          state_d    = WAIT_FE;
          fetch_en_d = 1'b0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_sync_q   <= '0;
      state_q     <= HOLD;
      cnt_q       <= '0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= 1'b0;
    end else begin
      fe_sync_q   <= fe_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
    end
  end

  assign soc_rst_no     = soc_rst_n_q;
  assign fetch_enable_o = fetch_en_q;
  assign boot_state_o   = state_q;

endmodule
